wrr_burst_scheduler: RTL and testbench

//  Shares one burst-oriented resource (bus/port) between NUM_REQ requesters.

---
 rtl/wrr_burst_scheduler.sv | 131 +++++++++++++
 tb/tb_wrr_burst_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/wrr_burst_scheduler.sv
// Weighted round-robin scheduler for a shared burst resource. A grant is held
// for a whole multi-beat burst; credits reload when no requester is eligible.
module wrr_burst_scheduler #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned WGT_W       = 4,
  parameter int unsigned INIT_WEIGHT = 3
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         last,
  input  logic                       beat_ack,
  input  logic                       cfg_we,
  input  logic [$clog2(NUM_REQ)-1:0] cfg_idx,
  input  logic [WGT_W-1:0]           cfg_wgt,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       busy,
  output logic                       round_done
);

  localparam int unsigned IW  = $clog2(NUM_REQ);
  localparam int unsigned IW1 = IW + 1;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [IW-1:0]      gnt_id_nxt;
  logic               busy_nxt;
  logic               round_done_nxt;
  logic [IW-1:0]      ptr, ptr_nxt, ptr_eff, winner;
  logic [WGT_W-1:0]   weight     [NUM_REQ];
  logic [WGT_W-1:0]   credit     [NUM_REQ];
  logic [WGT_W-1:0]   credit_eff [NUM_REQ];
  logic [WGT_W-1:0]   credit_nxt [NUM_REQ];
  logic [NUM_REQ-1:0] active;
  logic [NUM_REQ-1:0] elig;
  logic               end_burst;
  logic               arb;
  logic               found;
  logic [IW1-1:0]     scan_idx;

  // Burst end (last beat or abort) and the credit/pointer view arbitration sees
  always_comb begin
    end_burst  = (state == S_HOLD) && ((beat_ack && last[gnt_id]) || !req[gnt_id]);
    arb        = (state == S_IDLE) || end_burst;
    ptr_eff    = ptr;
    credit_eff = credit;
    if (end_burst) begin
      ptr_eff = (gnt_id == IW'(NUM_REQ - 1)) ? '0 : gnt_id + IW'(1);
      if (credit[gnt_id] != '0) begin
        credit_eff[gnt_id] = credit[gnt_id] - WGT_W'(1);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      active[i] = req[i] && (weight[i] != '0);
      elig[i]   = active[i] && (credit_eff[i] != '0);
    end
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, ptr_eff} + IW1'(k);
      if (scan_idx >= IW1'(NUM_REQ)) begin
        scan_idx = scan_idx - IW1'(NUM_REQ);
      end
      if (!found && elig[scan_idx[IW-1:0]]) begin
        found  = 1'b1;
        winner = scan_idx[IW-1:0];
      end
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_nxt      = state;
    gnt_nxt        = gnt;
    gnt_id_nxt     = gnt_id;
    busy_nxt       = busy;
    round_done_nxt = 1'b0;
    ptr_nxt        = ptr;
    credit_nxt     = credit;
    if (arb) begin
      ptr_nxt    = ptr_eff;
      credit_nxt = credit_eff;
      if (found) begin
        state_nxt  = S_HOLD;
        gnt_nxt    = NUM_REQ'(1) << winner;
        gnt_id_nxt = winner;
        busy_nxt   = 1'b1;
      end else begin
        state_nxt = S_IDLE;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
        // Reload only if someone enabled is waiting; avoids a reload livelock
        if (|active) begin
          credit_nxt     = weight;
          round_done_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= S_IDLE;
      gnt        <= '0;
      gnt_id     <= '0;
      busy       <= 1'b0;
      round_done <= 1'b0;
      ptr        <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        weight[i] <= WGT_W'(INIT_WEIGHT);
        credit[i] <= WGT_W'(INIT_WEIGHT);
      end
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      gnt_id     <= gnt_id_nxt;
      busy       <= busy_nxt;
      round_done <= round_done_nxt;
      ptr        <= ptr_nxt;
      credit     <= credit_nxt;
      if (cfg_we && ({1'b0, cfg_idx} < IW1'(NUM_REQ))) begin
        weight[cfg_idx] <= cfg_wgt;
      end
    end
  end

endmodule

// File: tb/tb_wrr_burst_scheduler.sv
// Scoreboard bench for wrr_burst_scheduler: an integer-level reference model
// predicts every cycle's outputs; directed sequences add fixed expectations.
module tb_wrr_burst_scheduler;

  localparam int N    = 4;
  localparam int W    = 4;
  localparam int INIT = 3;

  logic         clk      = 1'b0;
  logic         rst_b    = 1'b0;
  logic [N-1:0] req      = '0;
  logic [N-1:0] last     = '0;
  logic         beat_ack = 1'b0;
  logic         cfg_we   = 1'b0;
  logic [1:0]   cfg_idx  = '0;
  logic [W-1:0] cfg_wgt  = '0;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy;
  logic         round_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wrr_burst_scheduler #(.NUM_REQ(N), .WGT_W(W), .INIT_WEIGHT(INIT)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .req        (req),
    .last       (last),
    .beat_ack   (beat_ack),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_wgt    (cfg_wgt),
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .busy       (busy),
    .round_done (round_done)
  );

  task automatic chk(input string name, input bit ok, input string act, input string exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %s, expected %s (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 = none), per-requester credit/weight, round pointer
  typedef struct {
    logic [N-1:0] gnt;
    int           id;
    logic         busy;
    logic         rd;
  } exp_t;

  exp_t expq[$];
  int   m_owner;
  int   m_ptr;
  int   m_cred[N];
  int   m_wgt[N];

  task automatic model_step();
    int   nc[N];
    int   np;
    int   win;
    bit   arbitrate;
    bit   any;
    bit   rd;
    exp_t e;
    nc        = m_cred;
    np        = m_ptr;
    arbitrate = (m_owner < 0);
    rd        = 1'b0;
    if (m_owner >= 0) begin
      if ((beat_ack && last[m_owner]) || !req[m_owner]) begin
        if (nc[m_owner] > 0) nc[m_owner]--;
        np        = (m_owner + 1) % N;
        arbitrate = 1'b1;
      end
    end
    if (arbitrate) begin
      win = -1;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (np + k) % N;
        if (win < 0 && req[i] && nc[i] > 0 && m_wgt[i] > 0) win = i;
      end
      if (win < 0) begin
        any = 1'b0;
        for (int i = 0; i < N; i++) if (req[i] && m_wgt[i] > 0) any = 1'b1;
        if (any) begin
          nc = m_wgt;
          rd = 1'b1;
        end
      end
      m_owner = win;
      m_ptr   = np;
      m_cred  = nc;
    end
    if (cfg_we) m_wgt[int'(cfg_idx)] = int'(cfg_wgt);
    e.gnt  = (m_owner >= 0) ? (4'(1) << m_owner) : '0;
    e.id   = m_owner;
    e.busy = (m_owner >= 0);
    e.rd   = rd;
    expq.push_back(e);
  endtask

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_owner = -1;
      m_ptr   = 0;
      for (int i = 0; i < N; i++) begin
        m_cred[i] = INIT;
        m_wgt[i]  = INIT;
      end
      expq.delete();
    end else begin
      model_step();
    end
  end

  // Monitor: compare DUT outputs against the oldest prediction each cycle
  always @(negedge clk) begin
    exp_t e;
    if (!rst_b) begin
      chk("reset_state", gnt == '0 && gnt_id == '0 && !busy && !round_done,
          $sformatf("gnt=%b id=%0d busy=%b rd=%b", gnt, gnt_id, busy, round_done),
          "gnt=0000 id=0 busy=0 rd=0");
    end else if (expq.size() == 0) begin
      chk("scoreboard_empty", 1'b0, "no prediction", "one prediction per cycle");
    end else begin
      e = expq.pop_front();
      chk("scoreboard",
          gnt == e.gnt && busy == e.busy && round_done == e.rd && (!e.busy || int'(gnt_id) == e.id),
          $sformatf("gnt=%b id=%0d busy=%b rd=%b", gnt, gnt_id, busy, round_done),
          $sformatf("gnt=%b id=%0d busy=%b rd=%b", e.gnt, e.id, e.busy, e.rd));
    end
  end

  int seq_exp[20]  = '{0, 1, 2, 0, 1, 2, 0, 1, 2, -1, 0, 1, 2, 0, -1, 1, 2, 0, 0, -1};
  int busy_exp[12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1};

  task automatic do_reset();
    @(negedge clk); #1 rst_b = 1'b0;
    req = '0; last = '0; beat_ack = 1'b0; cfg_we = 1'b0;
    @(negedge clk); #1 rst_b = 1'b1;
  endtask

  initial begin
    int obs;
    int bc;
    repeat (3) @(negedge clk);
    #1 rst_b = 1'b1;

    // Weights 2/1/1/0, credits start at 3 from reset
    @(negedge clk); #1 cfg_we = 1'b1; cfg_idx = 2'd0; cfg_wgt = 4'd2;
    @(negedge clk); #1 cfg_idx = 2'd1; cfg_wgt = 4'd1;
    @(negedge clk); #1 cfg_idx = 2'd2; cfg_wgt = 4'd1;
    @(negedge clk); #1 cfg_idx = 2'd3; cfg_wgt = 4'd0;
    @(negedge clk); #1 cfg_we = 1'b0; req = 4'b0111; last = '1; beat_ack = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      obs = busy ? int'(gnt_id) : -1;
      chk($sformatf("wrr_seq[%0d]", c), obs == seq_exp[c] && (obs >= 0 || round_done == (c != 19 || 1'b1)),
          $sformatf("owner=%0d", obs), $sformatf("owner=%0d", seq_exp[c]));
    end

    // Disable requester 2, then only it requests: no grant, no reload
    #1 cfg_we = 1'b1; cfg_idx = 2'd2; cfg_wgt = 4'd0;
    @(negedge clk); #1 cfg_we = 1'b0;
    repeat (10) @(negedge clk);
    #1 req = 4'b0100;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("no_livelock", !busy && !round_done,
          $sformatf("busy=%b rd=%b", busy, round_done), "busy=0 rd=0");
    end

    // Single requester, 3-beat bursts, weight 3
    do_reset();
    #0 req = 4'b0010; beat_ack = 1'b1; last = '0;
    bc = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("burst3[%0d]", c), int'(busy) == busy_exp[c] && (busy == 1'b0 || gnt == 4'b0010),
          $sformatf("busy=%b gnt=%b", busy, gnt), $sformatf("busy=%0d", busy_exp[c]));
      #1;
      if (busy) begin
        last = (bc == 2) ? 4'b0010 : 4'b0000;
        bc   = (bc == 2) ? 0 : bc + 1;
      end else begin
        last = '0;
        bc   = 0;
      end
    end

    // Abort on beat 2 of a 4-beat burst, next grant goes to requester 1
    do_reset();
    #0 req = 4'b0011; last = '0; beat_ack = 1'b1;
    @(negedge clk);
    chk("abort_first_gnt", gnt == 4'b0001, $sformatf("gnt=%b", gnt), "gnt=0001");
    #1 req = 4'b0010;
    @(negedge clk);
    chk("abort_next_gnt", gnt == 4'b0010, $sformatf("gnt=%b", gnt), "gnt=0010");

    // Asynchronous reset mid-burst
    #1 rst_b = 1'b0;
    #1;
    chk("async_reset_drop", gnt == '0 && !busy, $sformatf("gnt=%b busy=%b", gnt, busy), "gnt=0000 busy=0");
    @(negedge clk); #1 rst_b = 1'b1; req = 4'b1111;
    @(negedge clk);
    chk("post_reset_first", gnt == 4'b0001 && gnt_id == 2'd0,
        $sformatf("gnt=%b id=%0d", gnt, gnt_id), "gnt=0001 id=0");

    // Randomised traffic with runtime weight changes and aborts
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      for (int i = 0; i < N; i++) if ($urandom_range(9) == 0) req[i] = ~req[i];
      for (int i = 0; i < N; i++) last[i] = ($urandom_range(2) == 0);
      beat_ack = ($urandom_range(3) != 0);
      cfg_we   = ($urandom_range(15) == 0);
      cfg_idx  = 2'($urandom_range(N - 1));
      cfg_wgt  = 4'($urandom_range(3));
    end
    #1 cfg_we = 1'b0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
